// File: rtl/alt_mem_ddrx_burst_pkg.sv
// Shared definitions for the write-data burst tracker and burst consumer:
// consumer debug state encodings and the default width constants both sides agree on.
package alt_mem_ddrx_burst_pkg;

    localparam int DEF_BURSTCOUNT_TRACKING_WIDTH = 7;
    localparam int DEF_BUFFER_ADDR_WIDTH         = 6;
    localparam int DEF_INT_SIZE_WIDTH            = 4;
    localparam int DEF_CMD_FIFO_DEPTH            = 8;
    localparam int DEF_CMD_FIFO_ADDR_WIDTH       = 3;

    typedef enum logic [1:0] {
        CONSUMER_EMPTY     = 2'd0,
        CONSUMER_WAIT_DATA = 2'd1,
        CONSUMER_STALL_OUT = 2'd2,
        CONSUMER_RELEASE   = 2'd3
    } consumer_state_t;

endpackage

// File: rtl/alt_mem_ddrx_cmd_fifo.sv
// Synchronous FIFO with occupancy level; a push is visible at the head one cycle later.
// Backpressure via full; a push while full is only taken together with a pop.
module alt_mem_ddrx_cmd_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  ctl_clk,
    input  logic                  ctl_reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_dat,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // DEPTH is a power of two, so the level MSB alone marks full
    assign full    = level[ADDR_WIDTH];
    assign empty   = (level == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge ctl_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alt_mem_ddrx_burst_consumer.sv
// Holds write commands until their beats are pending, then consumes and releases them (1 cmd/cycle).
// Consume strobe is combinational; release is registered (+1 cycle) and held while release_ready is low.
module alt_mem_ddrx_burst_consumer
    import alt_mem_ddrx_burst_pkg::*;
#(
    parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = DEF_BURSTCOUNT_TRACKING_WIDTH,
    parameter int CFG_BUFFER_ADDR_WIDTH         = DEF_BUFFER_ADDR_WIDTH,
    parameter int CFG_INT_SIZE_WIDTH            = DEF_INT_SIZE_WIDTH,
    parameter int CFG_CMD_FIFO_DEPTH            = DEF_CMD_FIFO_DEPTH,
    parameter int CFG_CMD_FIFO_ADDR_WIDTH       = DEF_CMD_FIFO_ADDR_WIDTH
) (
    input  logic                                     ctl_clk,
    input  logic                                     ctl_reset,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [CFG_BUFFER_ADDR_WIDTH-1:0]         cmd_dataid,
    input  logic [CFG_INT_SIZE_WIDTH-1:0]            cmd_size,
    input  logic [CFG_BURSTCOUNT_TRACKING_WIDTH-1:0] burst_pending_burstcount,
    output logic                                     burst_consumed_valid,
    output logic [CFG_INT_SIZE_WIDTH-1:0]            burst_counsumed_burstcount,
    output logic                                     release_valid,
    input  logic                                     release_ready,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0]         release_dataid,
    output logic [CFG_INT_SIZE_WIDTH-1:0]            release_size,
    output logic [CFG_CMD_FIFO_ADDR_WIDTH:0]         cmd_fifo_level,
    output logic [1:0]                               consumer_state
);

    typedef struct packed {
        logic [CFG_BUFFER_ADDR_WIDTH-1:0] dataid;
        logic [CFG_INT_SIZE_WIDTH-1:0]    size;
    } cmd_t;

    cmd_t            push_cmd;
    cmd_t            head;
    cmd_t            rel_cmd;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head_vld;
    logic            beats_ok;
    logic            out_free;
    logic            consume;
    consumer_state_t state;

    assign push_cmd.dataid = cmd_dataid;
    assign push_cmd.size   = cmd_size;
    assign cmd_ready       = ~ctl_reset & ~fifo_full;

    alt_mem_ddrx_cmd_fifo #(
        .WIDTH      ($bits(cmd_t)),
        .DEPTH      (CFG_CMD_FIFO_DEPTH),
        .ADDR_WIDTH (CFG_CMD_FIFO_ADDR_WIDTH)
    ) u_cmd_fifo (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .push      (cmd_valid & cmd_ready),
        .push_dat  (push_cmd),
        .pop       (consume),
        .pop_dat   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (cmd_fifo_level)
    );

    // The tracker folds this cycle's consumption into pending by next cycle,
    // so comparing against the raw pending count is enough for back-to-back consumes.
    assign head_vld = ~fifo_empty;
    assign beats_ok = burst_pending_burstcount >= CFG_BURSTCOUNT_TRACKING_WIDTH'(head.size);
    assign out_free = ~release_valid | release_ready;
    assign consume  = ~ctl_reset & head_vld & out_free & beats_ok;

    assign burst_consumed_valid       = consume;
    assign burst_counsumed_burstcount = consume ? head.size : '0;

    always_comb begin
        state = CONSUMER_EMPTY;
        if (ctl_reset || !head_vld) begin
            state = CONSUMER_EMPTY;
        end else if (!beats_ok) begin
            state = CONSUMER_WAIT_DATA;
        end else if (!out_free) begin
            state = CONSUMER_STALL_OUT;
        end else begin
            state = CONSUMER_RELEASE;
        end
    end

    assign consumer_state = state;

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            release_valid <= 1'b0;
            rel_cmd       <= '0;
        end else if (consume) begin
            release_valid <= 1'b1;
            rel_cmd       <= head;
        end else if (release_ready) begin
            release_valid <= 1'b0;
        end
    end

    assign release_dataid = rel_cmd.dataid;
    assign release_size   = rel_cmd.size;

endmodule

// File: tb/tb_alt_mem_ddrx_burst_consumer.sv
// Bench for alt_mem_ddrx_burst_consumer: vector table plus scripted corner sequences,
// with a tracker model and a command scoreboard watching every consume and release.
module tb_alt_mem_ddrx_burst_consumer;
    import alt_mem_ddrx_burst_pkg::*;

    logic       ctl_clk;
    logic       ctl_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_dataid;
    logic [3:0] cmd_size;
    logic [6:0] pending;
    logic       bcv;
    logic [3:0] bcb;
    logic       release_valid;
    logic       release_ready;
    logic [5:0] release_dataid;
    logic [3:0] release_size;
    logic [3:0] level;
    logic [1:0] cstate;

    int n_checks = 0;
    int n_fail   = 0;
    int add_total = 0;
    logic [3:0] cons_amt = '0;

    typedef struct packed {
        logic [5:0] id;
        logic [3:0] sz;
    } ent_t;

    ent_t cons_q[$];
    ent_t rel_q[$];

    typedef struct {
        logic [5:0] id;
        logic [3:0] sz;
        logic [6:0] pend;
        logic [1:0] st;
        logic       cv;
        logic [3:0] bc;
    } vec_t;

    vec_t vt[8];

    alt_mem_ddrx_burst_consumer dut (
        .ctl_clk                    (ctl_clk),
        .ctl_reset                  (ctl_reset),
        .cmd_valid                  (cmd_valid),
        .cmd_ready                  (cmd_ready),
        .cmd_dataid                 (cmd_dataid),
        .cmd_size                   (cmd_size),
        .burst_pending_burstcount   (pending),
        .burst_consumed_valid       (bcv),
        .burst_counsumed_burstcount (bcb),
        .release_valid              (release_valid),
        .release_ready              (release_ready),
        .release_dataid             (release_dataid),
        .release_size               (release_size),
        .cmd_fifo_level             (level),
        .consumer_state             (cstate)
    );

    initial begin
        ctl_clk = 1'b0;
        forever #5 ctl_clk = ~ctl_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Tracker model: registered pending count, adds requested beats, subtracts consumptions.
    initial begin : trk
        logic rs;
        int   seen;
        pending = '0;
        seen    = 0;
        forever begin
            @(posedge ctl_clk);
            rs = ctl_reset;
            #1;
            if (rs) begin
                pending = '0;
                seen    = add_total;
            end else begin
                pending = pending + 7'(add_total - seen) - {3'b000, cons_amt};
                seen    = add_total;
            end
        end
    end

    // Scoreboard: accepted commands must be consumed and released in order with matching fields.
    initial begin : mon
        ent_t e;
        forever begin
            @(negedge ctl_clk);
            if (ctl_reset) begin
                cons_q.delete();
                rel_q.delete();
                cons_amt = '0;
                chk("rst_no_consume", bcv, 0);
            end else begin
                if (release_valid && release_ready) begin
                    chk("release_has_cmd", int'(rel_q.size() > 0), 1);
                    if (rel_q.size() > 0) begin
                        e = rel_q.pop_front();
                        chk("release_dataid", release_dataid, e.id);
                        chk("release_size", release_size, e.sz);
                    end
                end
                if (bcv) begin
                    chk("consume_has_cmd", int'(cons_q.size() > 0), 1);
                    if (cons_q.size() > 0) begin
                        e = cons_q.pop_front();
                        chk("consume_burstcount", bcb, e.sz);
                        chk("no_underflow", int'(pending >= {3'b000, bcb}), 1);
                        rel_q.push_back(e);
                    end
                    cons_amt = bcb;
                end else begin
                    chk("idle_burstcount", bcb, 0);
                    cons_amt = '0;
                end
                if (cmd_valid && cmd_ready) begin
                    cons_q.push_back('{id: cmd_dataid, sz: cmd_size});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ctl_clk);
            #2;
        end
    endtask

    task automatic at_neg();
        @(negedge ctl_clk);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        ctl_reset = 1'b1;
        step(1);
        ctl_reset = 1'b0;
    endtask

    task automatic add_beats(input int n);
        add_total = add_total + n;
        step(1);
    endtask

    task automatic push(input logic [5:0] id, input logic [3:0] sz);
        cmd_valid  = 1'b1;
        cmd_dataid = id;
        cmd_size   = sz;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        vt[0] = '{6'd1,  4'd4,  7'd3,   CONSUMER_WAIT_DATA, 1'b0, 4'd0};
        vt[1] = '{6'd2,  4'd4,  7'd4,   CONSUMER_RELEASE,   1'b1, 4'd4};
        vt[2] = '{6'd3,  4'd4,  7'd5,   CONSUMER_RELEASE,   1'b1, 4'd4};
        vt[3] = '{6'd4,  4'd0,  7'd0,   CONSUMER_RELEASE,   1'b1, 4'd0};
        vt[4] = '{6'd5,  4'd15, 7'd14,  CONSUMER_WAIT_DATA, 1'b0, 4'd0};
        vt[5] = '{6'd6,  4'd15, 7'd15,  CONSUMER_RELEASE,   1'b1, 4'd15};
        vt[6] = '{6'd7,  4'd1,  7'd0,   CONSUMER_WAIT_DATA, 1'b0, 4'd0};
        vt[7] = '{6'd63, 4'd7,  7'd100, CONSUMER_RELEASE,   1'b1, 4'd7};

        ctl_reset     = 1'b1;
        cmd_valid     = 1'b0;
        cmd_dataid    = '0;
        cmd_size      = '0;
        release_ready = 1'b1;

        // Reset state
        step(2);
        at_neg();
        chk("cmd_ready_in_reset", cmd_ready, 0);
        step(1);
        ctl_reset = 1'b0;
        at_neg();
        chk("rst_level", level, 0);
        chk("rst_release_valid", release_valid, 0);
        chk("rst_release_dataid", release_dataid, 0);
        chk("rst_release_size", release_size, 0);
        chk("rst_state", cstate, CONSUMER_EMPTY);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_consumed_valid", bcv, 0);

        // Vector table: one command against a given pending count
        for (int i = 0; i < 8; i++) begin
            do_reset();
            add_beats(int'(vt[i].pend));
            push(vt[i].id, vt[i].sz);
            at_neg();
            chk("vec_state", cstate, vt[i].st);
            chk("vec_consumed_valid", bcv, vt[i].cv);
            chk("vec_burstcount", bcb, vt[i].bc);
            step(1);
            at_neg();
            chk("vec_release_valid", release_valid, vt[i].cv);
            chk("vec_release_dataid", release_dataid, vt[i].cv ? vt[i].id : 6'd0);
            chk("vec_level", level, vt[i].cv ? 0 : 1);
        end

        // Wait for data, then consume once pending covers the size
        do_reset();
        add_beats(3);
        push(6'd5, 4'd4);
        at_neg();
        chk("A_state_wait", cstate, CONSUMER_WAIT_DATA);
        chk("A_no_consume", bcv, 0);
        add_beats(1);
        at_neg();
        chk("A_consume", bcv, 1);
        chk("A_burstcount", bcb, 4);
        chk("A_state_release", cstate, CONSUMER_RELEASE);
        step(1);
        at_neg();
        chk("A_release_valid", release_valid, 1);
        chk("A_release_dataid", release_dataid, 5);
        chk("A_release_size", release_size, 4);
        chk("A_single_strobe", bcv, 0);
        chk("A_pending_end", pending, 0);

        // Back-to-back consumes tracked through the pending feedback
        do_reset();
        push(6'd1, 4'd2);
        push(6'd2, 4'd2);
        push(6'd3, 4'd2);
        add_beats(6);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("B_consume", bcv, 1);
            chk("B_burstcount", bcb, 2);
            chk("B_pending_seen", pending, 6 - 2 * i);
            step(1);
        end
        at_neg();
        chk("B_idle", bcv, 0);
        chk("B_pending_end", pending, 0);
        chk("B_state_empty", cstate, CONSUMER_EMPTY);
        chk("B_level_empty", level, 0);

        // Release hold with a second command ready behind it
        do_reset();
        release_ready = 1'b0;
        add_beats(2);
        push(6'd7, 4'd1);
        push(6'd8, 4'd1);
        at_neg();
        chk("C_release_valid", release_valid, 1);
        chk("C_release_dataid", release_dataid, 7);
        chk("C_state_stall", cstate, CONSUMER_STALL_OUT);
        chk("C_no_consume", bcv, 0);
        step(2);
        at_neg();
        chk("C_hold_dataid", release_dataid, 7);
        chk("C_hold_valid", release_valid, 1);
        chk("C_hold_state", cstate, CONSUMER_STALL_OUT);
        chk("C_hold_no_consume", bcv, 0);
        chk("C_hold_level", level, 1);
        step(1);
        release_ready = 1'b1;
        at_neg();
        chk("C_consume_on_ready", bcv, 1);
        chk("C_burstcount", bcb, 1);
        chk("C_state_release", cstate, CONSUMER_RELEASE);
        step(1);
        at_neg();
        chk("C_release2_valid", release_valid, 1);
        chk("C_release2_dataid", release_dataid, 8);
        chk("C_pending_end", pending, 0);

        // Fill to full, ignored push, drain, refill across the pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(6'(10 + i), 4'd1);
        end
        at_neg();
        chk("D_cmd_ready_full", cmd_ready, 0);
        chk("D_level_full", level, 8);
        chk("D_state_wait", cstate, CONSUMER_WAIT_DATA);
        step(1);
        cmd_valid  = 1'b1;
        cmd_dataid = 6'd63;
        cmd_size   = 4'd1;
        step(1);
        cmd_valid  = 1'b0;
        at_neg();
        chk("D_level_after_ignored_push", level, 8);
        add_beats(15);
        step(8);
        at_neg();
        chk("D_level_drained", level, 0);
        chk("D_pending_drained", pending, 7);
        step(1);
        push(6'd20, 4'd2);
        push(6'd21, 4'd2);
        push(6'd22, 4'd2);
        step(1);
        at_neg();
        chk("D_level_refill", level, 0);
        chk("D_pending_refill", pending, 1);

        // Size-0 command with nothing pending
        do_reset();
        push(6'd33, 4'd0);
        at_neg();
        chk("E_consume", bcv, 1);
        chk("E_burstcount", bcb, 0);
        chk("E_state", cstate, CONSUMER_RELEASE);
        step(1);
        at_neg();
        chk("E_release_valid", release_valid, 1);
        chk("E_release_dataid", release_dataid, 33);
        chk("E_release_size", release_size, 0);
        chk("E_pending", pending, 0);

        // Reset while a release is held and commands are queued
        do_reset();
        release_ready = 1'b0;
        push(6'd40, 4'd0);
        push(6'd41, 4'd3);
        push(6'd42, 4'd3);
        push(6'd43, 4'd3);
        at_neg();
        chk("F_level_before", level, 3);
        chk("F_release_valid_before", release_valid, 1);
        chk("F_release_dataid_before", release_dataid, 40);
        step(1);
        ctl_reset = 1'b1;
        at_neg();
        chk("F_no_consume_in_reset", bcv, 0);
        chk("F_cmd_ready_in_reset", cmd_ready, 0);
        step(1);
        ctl_reset = 1'b0;
        at_neg();
        chk("F_level_after", level, 0);
        chk("F_release_valid_after", release_valid, 0);
        chk("F_no_consume_after", bcv, 0);
        chk("F_state_after", cstate, CONSUMER_EMPTY);
        step(1);
        release_ready = 1'b1;
        add_beats(1);
        push(6'd50, 4'd1);
        at_neg();
        chk("F_resume_consume", bcv, 1);
        chk("F_resume_burstcount", bcb, 1);
        step(1);
        at_neg();
        chk("F_resume_release_valid", release_valid, 1);
        chk("F_resume_release_dataid", release_dataid, 50);
        chk("sb_cons_q_empty", cons_q.size(), 0);
        chk("sb_rel_q_empty", rel_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
